// File: rtl/video_timing.sv
// Raster timing generator: free-running h/v counters decoded into registered
// de / hsync / vsync, raster position and line/frame start strobes.
module video_timing #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FRONT    = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BACK     = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FRONT    = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BACK     = 33,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] h_pos,
    output logic [11:0] v_pos,
    output logic        line_start,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    // Region bounds are 13 bits so a 4096 total still compares correctly.
    localparam logic [12:0] H_DE_END   = 13'(H_ACTIVE);
    localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FRONT);
    localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [12:0] V_DE_END   = 13'(V_ACTIVE);
    localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FRONT);
    localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [11:0] hc, vc;
    logic        h_act, v_act, h_syn, v_syn;

    always_comb begin
        h_act = {1'b0, hc} < H_DE_END;
        v_act = {1'b0, vc} < V_DE_END;
        h_syn = ({1'b0, hc} >= H_SYNC_BEG) && ({1'b0, hc} < H_SYNC_END);
        v_syn = ({1'b0, vc} >= V_SYNC_BEG) && ({1'b0, vc} < V_SYNC_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc          <= '0;
            vc          <= '0;
            de          <= 1'b0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            h_pos       <= '0;
            v_pos       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 12'd1;
            end else begin
                hc <= hc + 12'd1;
            end
            // Outputs decode the pre-increment count, so everything lines up.
            de          <= h_act && v_act;
            hsync       <= h_syn ? H_SYNC_POL : ~H_SYNC_POL;
            vsync       <= v_syn ? V_SYNC_POL : ~V_SYNC_POL;
            h_pos       <= hc;
            v_pos       <= vc;
            line_start  <= (hc == '0);
            frame_start <= (hc == '0) && (vc == '0);
        end else begin
            // Stalled: hold levels but never repeat a strobe.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: defaults, a mid-size raster and the minimal raster
// share clk/rst/en; table vectors on the minimal one plus frame-level sequences.
module tb_video_timing;
    logic clk = 1'b0;
    logic rst, en;
    always #5 clk = ~clk;

    logic        d_de, d_hs, d_vs, d_ls, d_fs;
    logic [11:0] d_h, d_v;
    logic        m_de, m_hs, m_vs, m_ls, m_fs;
    logic [11:0] m_h, m_v;
    logic        n_de, n_hs, n_vs, n_ls, n_fs;
    logic [11:0] n_h, n_v;

    video_timing dflt (.clk(clk), .rst(rst), .en(en), .de(d_de), .hsync(d_hs), .vsync(d_vs),
                       .h_pos(d_h), .v_pos(d_v), .line_start(d_ls), .frame_start(d_fs));

    // H 16/2/3/4 = 25, V 12/2/2/3 = 19, frame 475 cycles
    video_timing #(.H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
                   .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3))
        mid (.clk(clk), .rst(rst), .en(en), .de(m_de), .hsync(m_hs), .vsync(m_vs),
             .h_pos(m_h), .v_pos(m_v), .line_start(m_ls), .frame_start(m_fs));

    // H 4/1/1/1 = 7, V 2/1/1/1 = 5, frame 35 cycles, active-high syncs
    video_timing #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
                   .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1))
        mn (.clk(clk), .rst(rst), .en(en), .de(n_de), .hsync(n_hs), .vsync(n_vs),
            .h_pos(n_h), .v_pos(n_v), .line_start(n_ls), .frame_start(n_fs));

    logic [28:0] d_o, m_o, n_o;
    assign d_o = {d_de, d_hs, d_vs, d_h, d_v, d_ls, d_fs};
    assign m_o = {m_de, m_hs, m_vs, m_h, m_v, m_ls, m_fs};
    assign n_o = {n_de, n_hs, n_vs, n_h, n_v, n_ls, n_fs};

    int checks = 0;
    int errors = 0;
    int hold_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic tick(input logic r, input logic e);
        logic [28:0] pd, pm, pn;
        pd = d_o; pm = m_o; pn = n_o;
        rst = r; en = e;
        @(posedge clk); #1;
        if (!r && !e) begin
            if (d_o[28:2] !== pd[28:2] || d_o[1:0] !== 2'b00) hold_bad++;
            if (m_o[28:2] !== pm[28:2] || m_o[1:0] !== 2'b00) hold_bad++;
            if (n_o[28:2] !== pn[28:2] || n_o[1:0] !== 2'b00) hold_bad++;
        end
    endtask

    typedef struct {
        logic r, e, de, hs, vs;
        logic [11:0] h, v;
        logic ls, fs;
    } vec_t;

    function automatic vec_t mk(input int r, e, de, hs, vs, h, v, ls, fs);
        vec_t t;
        t.r = r[0]; t.e = e[0]; t.de = de[0]; t.hs = hs[0]; t.vs = vs[0];
        t.h = h[11:0]; t.v = v[11:0]; t.ls = ls[0]; t.fs = fs[0];
        return t;
    endfunction

    vec_t tbl[13];

    initial begin
        int q_m_fs[$], q_n_fs[$], q_d_ls[$], q_m_de[$], q_m_lsc[$], q_m_en[$], q_n_en[$];
        int cyc, m_dec, m_lsc, m_seen, bad_m, bad_n, bad_d, d_hs_lo, d_de_cnt;
        int m_enc, n_enc, n_seen, found;
        logic pv, e;

        //        r  e de hs vs  h  v ls fs
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 0, 0, 0, 0, 1, 1);
        tbl[2]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0);
        tbl[4]  = mk(0, 1, 1, 0, 0, 2, 0, 0, 0);
        tbl[5]  = mk(0, 1, 1, 0, 0, 3, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 0, 4, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 1, 0, 5, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 0, 5, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 0, 6, 0, 0, 0);
        tbl[10] = mk(0, 1, 1, 0, 0, 0, 1, 1, 0);
        tbl[11] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(0, 1, 1, 0, 0, 0, 0, 1, 1);

        rst = 1'b1; en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Minimal raster, hand-computed vectors
        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].r, tbl[i].e);
            check($sformatf("min_vec[%0d]", i), {3'b0, n_o},
                  {3'b0, tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].h, tbl[i].v, tbl[i].ls, tbl[i].fs});
        end
        check("dflt_rst_on_en", {3'b0, d_o}, {3'b0, 1'b1, 1'b1, 1'b1, 24'd0, 1'b1, 1'b1});

        // Continuous run: shapes, periods, per-frame counts
        tick(1, 0);
        check("dflt_reset", {3'b0, d_o}, {3'b0, 1'b0, 1'b1, 1'b1, 24'd0, 2'b00});
        check("mid_reset", {3'b0, m_o}, {3'b0, 1'b0, 1'b1, 1'b1, 24'd0, 2'b00});
        check("min_reset", {3'b0, n_o}, 32'd0);
        cyc = 0; m_dec = 0; m_lsc = 0; m_seen = 0;
        bad_m = 0; bad_n = 0; bad_d = 0; d_hs_lo = 0; d_de_cnt = 0;
        pv = m_vs;
        for (int i = 0; i < 1600; i++) begin
            tick(0, 1);
            cyc++;
            if (m_fs) begin
                q_m_fs.push_back(cyc);
                if (m_seen != 0) begin q_m_de.push_back(m_dec); q_m_lsc.push_back(m_lsc); end
                m_seen = 1; m_dec = 0; m_lsc = 0;
            end
            if (m_de) m_dec++;
            if (m_ls) m_lsc++;
            if ((m_hs == 1'b0) != (m_h >= 18 && m_h <= 20)) bad_m++;
            if ((m_vs == 1'b0) != (m_v == 14 || m_v == 15)) bad_m++;
            if (m_vs != pv && m_h != 0) bad_m++;
            if (m_de != (m_h < 16 && m_v < 12)) bad_m++;
            if (m_de && (!m_hs || !m_vs)) bad_m++;
            if (m_ls != (m_h == 0)) bad_m++;
            pv = m_vs;
            if (n_fs) q_n_fs.push_back(cyc);
            if (n_hs != (n_h == 5)) bad_n++;
            if (n_vs != (n_v == 3)) bad_n++;
            if (d_ls) q_d_ls.push_back(cyc);
            if ((d_hs == 1'b0) != (d_h >= 656 && d_h <= 751)) bad_d++;
            if (d_de != (d_h < 640)) bad_d++;
            if (d_v == 0 && !d_hs) d_hs_lo++;
            if (d_v == 0 && d_de) d_de_cnt++;
        end
        check("mid_shape_bad", bad_m, 0);
        check("min_shape_bad", bad_n, 0);
        check("dflt_shape_bad", bad_d, 0);
        check("dflt_hsync_low_cnt", d_hs_lo, 96);
        check("dflt_de_line_cnt", d_de_cnt, 640);
        check("dflt_ls_cnt", q_d_ls.size(), 2);
        if (q_d_ls.size() >= 2) check("dflt_line_period", q_d_ls[1] - q_d_ls[0], 800);
        check("mid_fs_cnt", q_m_fs.size(), 4);
        for (int i = 1; i < q_m_fs.size(); i++)
            check($sformatf("mid_frame_period[%0d]", i), q_m_fs[i] - q_m_fs[i-1], 475);
        if (q_m_de.size() > 0) check("mid_de_per_frame", q_m_de[0], 192);
        if (q_m_lsc.size() > 0) check("mid_ls_per_frame", q_m_lsc[0], 19);
        check("min_fs_cnt", q_n_fs.size(), 46);
        bad_n = 0;
        for (int i = 1; i < q_n_fs.size(); i++)
            if (q_n_fs[i] - q_n_fs[i-1] != 35) bad_n++;
        check("min_frame_period_bad", bad_n, 0);

        // Random en: holds, and frame length counted in enabled cycles
        tick(1, 0);
        hold_bad = 0; m_enc = 0; n_enc = 0; m_seen = 0; n_seen = 0; bad_m = 0;
        for (int i = 0; i < 4000; i++) begin
            e = 1'($urandom_range(0, 1));
            tick(0, e);
            if (m_ls && m_h != 0) bad_m++;
            if (e) begin
                m_enc++; n_enc++;
                if (m_fs) begin
                    if (m_seen != 0) q_m_en.push_back(m_enc);
                    m_seen = 1; m_enc = 0;
                end
                if (n_fs) begin
                    if (n_seen != 0) q_n_en.push_back(n_enc);
                    n_seen = 1; n_enc = 0;
                end
            end
        end
        check("rand_hold_bad", hold_bad, 0);
        check("rand_ls_pos_bad", bad_m, 0);
        check("rand_mid_frames", 32'(q_m_en.size() >= 2), 1);
        for (int i = 0; i < q_m_en.size(); i++)
            check($sformatf("rand_mid_en_cycles[%0d]", i), q_m_en[i], 475);
        bad_n = 0;
        for (int i = 0; i < q_n_en.size(); i++)
            if (q_n_en[i] != 35) bad_n++;
        check("rand_min_en_bad", bad_n, 0);
        check("rand_min_frames", 32'(q_n_en.size() >= 20), 1);

        // Mid-line reset with en still high
        tick(1, 0);
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            tick(0, 1);
            if (d_h == 700) found = 1;
        end
        check("reach_h700", found, 1);
        tick(1, 1);
        check("midline_rst_dflt", {3'b0, d_o}, {3'b0, 1'b0, 1'b1, 1'b1, 24'd0, 2'b00});
        check("midline_rst_mid", {3'b0, m_o}, {3'b0, 1'b0, 1'b1, 1'b1, 24'd0, 2'b00});
        check("midline_rst_min", {3'b0, n_o}, 32'd0);
        tick(0, 0);
        check("post_rst_stall", {3'b0, d_o}, {3'b0, 1'b0, 1'b1, 1'b1, 24'd0, 2'b00});
        tick(0, 1);
        check("post_rst_first", {3'b0, d_o}, {3'b0, 1'b1, 1'b1, 1'b1, 24'd0, 1'b1, 1'b1});
        tick(0, 1);
        check("post_rst_second", {3'b0, d_o}, {3'b0, 1'b1, 1'b1, 1'b1, 12'd1, 12'd0, 2'b00});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/video_timing.md
# video_timing

Raster timing generator that produces the pixel-domain control stream for the TMDS encoders. It outputs the data-enable plus the horizontal and vertical sync levels that drive the encoder's `de`, `c0` and `c1` inputs, and the current raster position that pixel sources use to generate colour. The default parameters give CEA 640x480@60 (25.175 MHz pixel clock). All outputs are registered.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `H_SYNC_POL`, 0: asserted level of `hsync`. Idle level is the inverse.
- `V_SYNC_POL`, 0: asserted level of `vsync`. Idle level is the inverse.

Ports:
- `clk` input 1: pixel clock. This is the only clock.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: advance enable. While low, all state and outputs hold.
- `de` output 1: high inside the active region.
- `hsync` output 1: horizontal sync level. Connects to encoder `c0` on channel 0.
- `vsync` output 1: vertical sync level. Connects to encoder `c1` on channel 0.
- `h_pos` output 12: horizontal raster position, 0..H_TOTAL-1.
- `v_pos` output 12: vertical raster position, 0..V_TOTAL-1.
- `line_start` output 1: one-cycle pulse when `h_pos`==0.
- `frame_start` output 1: one-cycle pulse when `h_pos`==0 and `v_pos`==0.

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK. V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK.
- Both totals must be ≤ 4096. Every parameter must be ≥ 1.
- Internal counters `hc` and `vc` are 12 bits wide.
- Counter advance, on a cycle with `en`=1:
  - `hc` increments.
  - At `hc`==H_TOTAL-1, `hc` wraps to 0 and `vc` increments.
  - When that happens at `vc`==V_TOTAL-1, `vc` also wraps to 0.
- Raster order is active region first, then front porch, then sync, then back porch.
- Output decode is a registered function of the counter values before the increment:
  - `h_pos`=hc, `v_pos`=vc.
  - `de` = (hc < H_ACTIVE) && (vc < V_ACTIVE).
  - `hsync` = H_SYNC_POL when H_ACTIVE+H_FRONT ≤ hc < H_ACTIVE+H_FRONT+H_SYNC, else ~H_SYNC_POL.
  - `vsync` = V_SYNC_POL when V_ACTIVE+V_FRONT ≤ vc < V_ACTIVE+V_FRONT+V_SYNC, else ~V_SYNC_POL.
  - Because `vsync` depends only on `vc`, it changes only on cycles where `h_pos` becomes 0.
  - `line_start` = (hc==0). `frame_start` = (hc==0 && vc==0).
- On a cycle with `en`=0:
  - Counters hold.
  - `de`, `hsync`, `vsync`, `h_pos` and `v_pos` hold.
  - `line_start` and `frame_start` are forced to 0, so a position is never pulsed twice.
- Reset, taking effect on the next clock edge, including mid-frame:
  - `hc`=0, `vc`=0.
  - `de`=0, `hsync`=~H_SYNC_POL, `vsync`=~V_SYNC_POL.
  - `h_pos`=0, `v_pos`=0, `line_start`=0, `frame_start`=0.
- `rst` has priority over `en`.

## Timing
- Latency: outputs reflect the counter state from one `en` cycle earlier.
- First `en`=1 edge after reset released: outputs become `h_pos`=0, `v_pos`=0, `de`=1, `line_start`=1, `frame_start`=1.
- With `en` held high:
  - Line period is H_TOTAL cycles; frame period is H_TOTAL×V_TOTAL cycles.
  - `de`, `hsync` and `vsync` are mutually aligned with `h_pos`/`v_pos` on the same cycle.
  - The downstream encoder sees a coherent {de, c1, c0} every cycle.
- `de` and the sync pulses never overlap: every parameter is ≥1, so sync lies strictly outside the active region.

## Test plan
- Reset then run with `en`=1 and defaults -> `frame_start` pulses every 420000 cycles; exactly 307200 `de`-high cycles per frame; 525 `line_start` pulses per frame.
- Default hsync shape -> `hsync`=0 for exactly 96 consecutive cycles per line, from `h_pos`=656 through 751. `de` falls after `h_pos`=639.
- Default vsync shape -> `vsync`=0 exactly while `v_pos` ∈ {490,491}. Transitions occur only on cycles with `h_pos`=0. `de`=0 for all `v_pos` ≥ 480.
- Minimal params (H 4/1/1/1, V 2/1/1/1), both polarities 1 -> H_TOTAL=7, V_TOTAL=5.
  - `hsync`=1 only at `h_pos`=5; `vsync`=1 only at `v_pos`=3.
  - `frame_start` every 35 cycles.
- Randomly toggle `en` with defaults -> every output holds while `en`=0. No duplicate `line_start`/`frame_start`. Count of `en`=1 cycles between `frame_start` pulses = 420000.
- Assert `rst` for 1 cycle at `h_pos`=700, `v_pos`=300 -> next cycle all outputs at reset values. The first subsequent `en` edge yields `frame_start`=1, `de`=1, position (0,0).
